spi_master_seq: RTL and testbench

Transaction sequencer in front of the SPI master controller. It accepts one high-level request (command, address, dummy cycles, data word count, chip select, direction, single/quad) and drives the controller's configuration and strobe inputs. It streams TX words from a requester into the TX FIFO and RX words from the RX FIFO back to the requester, then waits for the controller to return to idle. It replaces register-level software sequencing for DMA/boot-loader style masters.

---
 rtl/spi_master_seq_pkg.sv | 23 ++
 rtl/spi_master_seq_wdog.sv | 27 ++
 rtl/spi_master_seq.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_seq_pkg.sv
// Shared types for the SPI transaction sequencer: FSM states, the status bit
// index and the {write, quad} encoding that selects the start strobe.
package spi_master_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_START,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int STATUS_IDLE_BIT = 0;

    typedef enum logic [1:0] {
        SEL_RD  = 2'b00,
        SEL_QRD = 2'b01,
        SEL_WR  = 2'b10,
        SEL_QWR = 2'b11
    } strobe_sel_t;

endpackage

// File: rtl/spi_master_seq_wdog.sv
// Per-transaction watchdog for the SPI sequencer: a saturating 16-bit counter
// that is cleared at START and flags expiry when it reaches TIMEOUT_CYCLES.
module spi_master_seq_wdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/spi_master_seq.sv
// SPI transaction sequencer: turns one high-level request into controller
// config, a start strobe and a data stream. Optional watchdog: SPI_SEQ_TIMEOUT_EN.
module spi_master_seq
    import spi_master_seq_pkg::*;
#(
    parameter int WORDS_W        = 11,
    parameter int DRAIN_HOLDOFF  = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic               req_quad,
    input  logic [31:0]        req_cmd,
    input  logic [5:0]         req_cmd_len,
    input  logic [31:0]        req_addr,
    input  logic [5:0]         req_addr_len,
    input  logic [15:0]        req_dummy,
    input  logic [WORDS_W-1:0] req_words,
    input  logic [1:0]         req_cs,
    input  logic [31:0]        wdata,
    input  logic               wvalid,
    output logic               wready,
    output logic [31:0]        rdata,
    output logic               rvalid,
    input  logic               rready,
    output logic               done,
    output logic               err,
    output logic [31:0]        spi_cmd,
    output logic [31:0]        spi_addr,
    output logic [5:0]         spi_cmd_len,
    output logic [5:0]         spi_addr_len,
    output logic [15:0]        spi_data_len,
    output logic [15:0]        spi_dummy_rd,
    output logic [15:0]        spi_dummy_wr,
    output logic [3:0]         spi_csreg,
    output logic               spi_rd,
    output logic               spi_wr,
    output logic               spi_qrd,
    output logic               spi_qwr,
    input  logic [31:0]        spi_status,
    output logic [31:0]        spi_data_tx,
    output logic               spi_data_tx_valid,
    input  logic               spi_data_tx_ready,
    input  logic [31:0]        spi_data_rx,
    input  logic               spi_data_rx_valid,
    output logic               spi_data_rx_ready
);

    seq_state_t         state;
    seq_state_t         next_state;
    strobe_sel_t        sel;
    logic [WORDS_W-1:0] words_left;
    logic [7:0]         drain_cnt;
    logic               in_data;
    logic               is_write;
    logic               data_hs;
    logic               holdoff_done;
    logic               timeout_hit;

    assign in_data      = (state == ST_DATA);
    assign is_write     = sel[1];
    assign data_hs      = is_write ? (wvalid && spi_data_tx_ready)
                                   : (spi_data_rx_valid && rready);
    assign holdoff_done = (int'(drain_cnt) + 1) >= DRAIN_HOLDOFF;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req_valid) next_state = ST_CFG;
            ST_CFG:   next_state = ST_START;
            ST_START: next_state = (words_left != '0) ? ST_DATA : ST_DRAIN;
            ST_DATA: begin
                if (timeout_hit) begin
                    next_state = ST_DONE;
                end else if (data_hs && words_left == WORDS_W'(1)) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (timeout_hit) begin
                    next_state = ST_DONE;
                end else if (holdoff_done && spi_status[STATUS_IDLE_BIT]) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Data streams are combinational pass-throughs gated to the active direction in DATA.
    always_comb begin
        req_ready         = (state == ST_IDLE);
        done              = (state == ST_DONE);
        spi_rd            = 1'b0;
        spi_qrd           = 1'b0;
        spi_wr            = 1'b0;
        spi_qwr           = 1'b0;
        if (state == ST_START) begin
            case (sel)
                SEL_RD:  spi_rd  = 1'b1;
                SEL_QRD: spi_qrd = 1'b1;
                SEL_WR:  spi_wr  = 1'b1;
                SEL_QWR: spi_qwr = 1'b1;
                default: spi_rd  = 1'b0;
            endcase
        end
        spi_data_tx_valid = in_data && is_write && wvalid;
        wready            = in_data && is_write && spi_data_tx_ready;
        rvalid            = in_data && !is_write && spi_data_rx_valid;
        spi_data_rx_ready = in_data && !is_write && rready;
    end

    assign spi_data_tx = wdata;
    assign rdata       = spi_data_rx;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel          <= SEL_RD;
            words_left   <= '0;
            drain_cnt    <= '0;
            spi_cmd      <= '0;
            spi_addr     <= '0;
            spi_cmd_len  <= '0;
            spi_addr_len <= '0;
            spi_data_len <= '0;
            spi_dummy_rd <= '0;
            spi_dummy_wr <= '0;
            spi_csreg    <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                sel          <= strobe_sel_t'({req_write, req_quad});
                words_left   <= req_words;
                spi_cmd      <= req_cmd;
                spi_addr     <= req_addr;
                spi_cmd_len  <= req_cmd_len;
                spi_addr_len <= req_addr_len;
                spi_data_len <= 16'({req_words, 5'b0});
                spi_dummy_rd <= req_write ? 16'd0 : req_dummy;
                spi_dummy_wr <= req_write ? req_dummy : 16'd0;
                spi_csreg    <= 4'b0001 << req_cs;
            end else if (in_data && data_hs) begin
                words_left <= words_left - WORDS_W'(1);
            end

            if (state != ST_DRAIN) begin
                drain_cnt <= '0;
            end else if (drain_cnt != 8'hFF) begin
                drain_cnt <= drain_cnt + 8'd1;
            end
        end
    end

    logic unused_status;
    assign unused_status = ^spi_status;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic wdog_expired;
    logic err_q;

    spi_master_seq_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (state == ST_START),
        .count_en(state == ST_DATA || state == ST_DRAIN),
        .expired (wdog_expired)
    );

    assign timeout_hit = wdog_expired && (state == ST_DATA || state == ST_DRAIN);

    // Remembers that DONE was reached through the watchdog rather than a normal finish.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err = err_q && (state == ST_DONE);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_seq.sv
// Scoreboard bench for spi_master_seq; the bench plays requester and SPI controller.
module tb_spi_master_seq;
    import spi_master_seq_pkg::*;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 65535;
`endif
    localparam logic [31:0] ST_BUSY = 32'hFFFF_FFFE;
    localparam logic [31:0] ST_IDL  = 32'h0000_0001;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid, req_ready, req_write, req_quad;
    logic [31:0] req_cmd, req_addr;
    logic [5:0]  req_cmd_len, req_addr_len;
    logic [15:0] req_dummy;
    logic [10:0] req_words;
    logic [1:0]  req_cs;
    logic [31:0] wdata, rdata;
    logic        wvalid, wready, rvalid, rready, done, err;
    logic [31:0] spi_cmd, spi_addr;
    logic [5:0]  spi_cmd_len, spi_addr_len;
    logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
    logic [3:0]  spi_csreg;
    logic        spi_rd, spi_wr, spi_qrd, spi_qwr;
    logic [31:0] spi_status;
    logic [31:0] spi_data_tx, spi_data_rx;
    logic        spi_data_tx_valid, spi_data_tx_ready, spi_data_rx_valid, spi_data_rx_ready;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    always #5 HCLK = ~HCLK;

    spi_master_seq #(
        .WORDS_W(11), .DRAIN_HOLDOFF(2), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_quad(req_quad),
        .req_cmd(req_cmd), .req_cmd_len(req_cmd_len), .req_addr(req_addr), .req_addr_len(req_addr_len),
        .req_dummy(req_dummy), .req_words(req_words), .req_cs(req_cs),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .done(done), .err(err),
        .spi_cmd(spi_cmd), .spi_addr(spi_addr), .spi_cmd_len(spi_cmd_len), .spi_addr_len(spi_addr_len),
        .spi_data_len(spi_data_len), .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr),
        .spi_csreg(spi_csreg), .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr),
        .spi_status(spi_status),
        .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid), .spi_data_tx_ready(spi_data_tx_ready),
        .spi_data_rx(spi_data_rx), .spi_data_rx_valid(spi_data_rx_valid), .spi_data_rx_ready(spi_data_rx_ready)
    );

    initial begin
        #300000;
        $display("[TB] FAIL global_time_limit expired");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_quad = 0; req_cmd = 0; req_cmd_len = 0;
        req_addr = 0; req_addr_len = 0; req_dummy = 0; req_words = 0; req_cs = 0;
        wdata = 0; wvalid = 0; rready = 0; spi_status = ST_IDL;
        spi_data_tx_ready = 0; spi_data_rx = 0; spi_data_rx_valid = 0;
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after the accept edge (CFG).
    task automatic issue_request(input logic w, input logic q, input logic [31:0] cmd, input logic [5:0] cl,
                                 input logic [31:0] addr, input logic [5:0] al, input logic [15:0] dummy,
                                 input logic [10:0] words, input logic [1:0] cs);
        req_write = w; req_quad = q; req_cmd = cmd; req_cmd_len = cl; req_addr = addr;
        req_addr_len = al; req_dummy = dummy; req_words = words; req_cs = cs; req_valid = 1;
        @(negedge HCLK);
        req_valid = 0;
    endtask

    task automatic test_reset();
        HRESETn = 0;
        idle_inputs();
        repeat (3) @(negedge HCLK);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if ({done, err} !== 2'b00) begin failures++; $display("[TB] FAIL reset_done_err got=%b exp=00", {done, err}); end
        checks++; if ({spi_rd, spi_qrd, spi_wr, spi_qwr} !== 4'b0) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=0000", {spi_rd, spi_qrd, spi_wr, spi_qwr}); end
        checks++; if ({spi_cmd, spi_addr, spi_data_len, spi_csreg} !== 84'd0) begin failures++; $display("[TB] FAIL reset_config got=%h exp=0", {spi_cmd, spi_addr, spi_data_len, spi_csreg}); end
        HRESETn = 1;
        @(negedge HCLK);
    endtask

    task automatic test_read(input bit quad, input int nwords, input int stall_at, input int stall_len);
        logic [31:0] words[$];
        logic [31:0] exp_word;
        logic [3:0]  exp_strobe;
        int idx, got, strobe_cnt, stall_left, idle_cnt;
        bit seen_done;
        exp_q.delete();
        for (int i = 0; i <= nwords; i++) words.push_back($urandom);
        for (int i = 0; i < nwords; i++) exp_q.push_back(words[i]);
        exp_strobe = quad ? 4'b0100 : 4'b1000;
        issue_request(1'b0, quad, 32'hEB00_0000, 6'd8, 32'h0000_1000, 6'd24, 16'd8, 11'(nwords), 2'd0);
        #1;
        checks++; if (spi_data_len !== 16'(nwords * 32)) begin failures++; $display("[TB] FAIL rd_data_len got=%0d exp=%0d", spi_data_len, nwords * 32); end
        checks++; if ({spi_dummy_rd, spi_dummy_wr} !== {16'd8, 16'd0}) begin failures++; $display("[TB] FAIL rd_dummy got=%h exp=00080000", {spi_dummy_rd, spi_dummy_wr}); end
        checks++; if ({spi_cmd, spi_addr, spi_cmd_len, spi_addr_len} !== {32'hEB00_0000, 32'h0000_1000, 6'd8, 6'd24}) begin failures++; $display("[TB] FAIL rd_cmd_addr got=%h/%h/%0d/%0d", spi_cmd, spi_addr, spi_cmd_len, spi_addr_len); end
        checks++; if ({spi_rd, spi_qrd, spi_wr, spi_qwr} !== 4'b0) begin failures++; $display("[TB] FAIL rd_strobe_in_cfg got=%b exp=0000", {spi_rd, spi_qrd, spi_wr, spi_qwr}); end
        @(negedge HCLK); #1;
        checks++; if ({spi_rd, spi_qrd, spi_wr, spi_qwr} !== exp_strobe) begin failures++; $display("[TB] FAIL rd_strobe got=%b exp=%b", {spi_rd, spi_qrd, spi_wr, spi_qwr}, exp_strobe); end
        spi_status = ST_BUSY;
        idx = 0; got = 0; strobe_cnt = 0; stall_left = stall_len; idle_cnt = 0; seen_done = 0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            @(negedge HCLK);
            if (stall_at >= 0 && got == stall_at && stall_left > 0) begin
                rready = 0; stall_left--;
            end else begin
                rready = 1;
            end
            spi_data_rx_valid = (idx < words.size());
            spi_data_rx = (idx < words.size()) ? words[idx] : 32'h0;
            if (got == nwords) begin
                idle_cnt++;
                if (idle_cnt >= 3) spi_status = ST_IDL;
            end
            #1;
            if (spi_rd | spi_qrd | spi_wr | spi_qwr) strobe_cnt++;
            if (done) begin
                seen_done = 1;
                checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rd_err got=%b exp=0", err); end
                checks++; if (spi_status[0] !== 1'b1) begin failures++; $display("[TB] FAIL rd_done_before_idle status=%b exp=1", spi_status[0]); end
            end
            if (!rready) begin
                checks++; if (spi_data_rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL rd_stall_ready got=%b exp=0", spi_data_rx_ready); end
                checks++; if (dut.words_left !== 11'(nwords - got)) begin failures++; $display("[TB] FAIL rd_stall_count got=%0d exp=%0d", dut.words_left, nwords - got); end
            end
            if (spi_data_rx_valid && spi_data_rx_ready) begin
                checks++; if (rvalid !== 1'b1) begin failures++; $display("[TB] FAIL rd_rvalid got=%b exp=1", rvalid); end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("[TB] FAIL rd_extra_word got=%h exp=none", rdata);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (rdata !== exp_word) begin failures++; $display("[TB] FAIL rd_data got=%h exp=%h", rdata, exp_word); end
                end
                idx++; got++;
            end
        end
        checks++; if (!seen_done) begin failures++; $display("[TB] FAIL rd_done_timeout got=0 exp=1"); end
        checks++; if (got != nwords) begin failures++; $display("[TB] FAIL rd_word_count got=%0d exp=%0d", got, nwords); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL rd_words_left_in_sb got=%0d exp=0", exp_q.size()); end
        checks++; if (strobe_cnt != 0) begin failures++; $display("[TB] FAIL rd_extra_strobes got=%0d exp=0", strobe_cnt); end
        spi_data_rx_valid = 0; rready = 0;
        @(negedge HCLK); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_back_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_write();
        logic [31:0] words[$];
        logic [31:0] exp_word;
        int idx, got, idle_cnt;
        bit in_data_m, seen_done, check_drain;
        exp_q.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        for (int i = 0; i < 3; i++) exp_q.push_back(words[i]);
        spi_data_tx_ready = 1; wvalid = 1; wdata = words[0];
        issue_request(1'b1, 1'b0, 32'h0200_0000, 6'd8, 32'h0000_2000, 6'd24, 16'd5, 11'd3, 2'd1);
        #1;
        checks++; if ({spi_data_tx_valid, wready} !== 2'b00) begin failures++; $display("[TB] FAIL wr_valid_in_cfg got=%b exp=00", {spi_data_tx_valid, wready}); end
        checks++; if ({spi_dummy_wr, spi_dummy_rd} !== {16'd5, 16'd0}) begin failures++; $display("[TB] FAIL wr_dummy got=%h exp=00050000", {spi_dummy_wr, spi_dummy_rd}); end
        checks++; if ({spi_data_len, spi_csreg} !== {16'd96, 4'b0010}) begin failures++; $display("[TB] FAIL wr_len_cs got=%0d/%b exp=96/0010", spi_data_len, spi_csreg); end
        @(negedge HCLK); #1;
        checks++; if ({spi_rd, spi_qrd, spi_wr, spi_qwr} !== 4'b0010) begin failures++; $display("[TB] FAIL wr_strobe got=%b exp=0010", {spi_rd, spi_qrd, spi_wr, spi_qwr}); end
        checks++; if (spi_data_tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL wr_valid_in_start got=%b exp=0", spi_data_tx_valid); end
        spi_status = ST_BUSY;
        idx = 0; got = 0; idle_cnt = 0; in_data_m = 1; seen_done = 0; check_drain = 0;
        for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
            @(negedge HCLK);
            wvalid = (cyc % 2 == 0);
            wdata = words[idx];
            if (got == 3) begin
                idle_cnt++;
                if (idle_cnt >= 3) spi_status = ST_IDL;
            end
            #1;
            if (check_drain) begin
                check_drain = 0;
                checks++; if (dut.state !== ST_DRAIN) begin failures++; $display("[TB] FAIL wr_enter_drain got=%0d exp=%0d", dut.state, ST_DRAIN); end
            end
            if (done) seen_done = 1;
            checks++; if (spi_data_tx_valid !== (in_data_m && wvalid)) begin failures++; $display("[TB] FAIL wr_tx_valid got=%b exp=%b", spi_data_tx_valid, in_data_m && wvalid); end
            if (in_data_m && wvalid) begin
                checks++; if (wready !== 1'b1) begin failures++; $display("[TB] FAIL wr_wready got=%b exp=1", wready); end
                exp_word = exp_q.pop_front();
                checks++; if (spi_data_tx !== exp_word) begin failures++; $display("[TB] FAIL wr_data got=%h exp=%h", spi_data_tx, exp_word); end
                idx++; got++;
                if (got == 3) begin in_data_m = 0; check_drain = 1; end
            end
        end
        checks++; if (!seen_done) begin failures++; $display("[TB] FAIL wr_done_timeout got=0 exp=1"); end
        checks++; if (got != 3) begin failures++; $display("[TB] FAIL wr_word_count got=%0d exp=3", got); end
        wvalid = 0; spi_data_tx_ready = 0;
        @(negedge HCLK);
    endtask

    task automatic test_cmd_only();
        spi_data_rx_valid = 1; spi_data_rx = 32'hDEAD_BEEF; rready = 1;
        issue_request(1'b0, 1'b0, 32'h9F00_0000, 6'd8, 32'h0, 6'd0, 16'd0, 11'd0, 2'd2);
        #1;
        checks++; if (spi_csreg !== 4'b0100) begin failures++; $display("[TB] FAIL cmd_csreg got=%b exp=0100", spi_csreg); end
        checks++; if (spi_data_len !== 16'd0) begin failures++; $display("[TB] FAIL cmd_data_len got=%0d exp=0", spi_data_len); end
        for (int n = 2; n <= 8; n++) begin
            @(negedge HCLK); #1;
            checks++; if (done !== (n == 5)) begin failures++; $display("[TB] FAIL cmd_done_n%0d got=%b exp=%b", n, done, n == 5); end
            checks++; if ({rvalid, spi_data_rx_ready} !== 2'b00) begin failures++; $display("[TB] FAIL cmd_no_data_n%0d got=%b exp=00", n, {rvalid, spi_data_rx_ready}); end
            if (n == 2) begin
                checks++; if ({spi_rd, spi_qrd, spi_wr, spi_qwr} !== 4'b1000) begin failures++; $display("[TB] FAIL cmd_strobe got=%b exp=1000", {spi_rd, spi_qrd, spi_wr, spi_qwr}); end
            end
        end
        spi_data_rx_valid = 0; rready = 0;
    endtask

    task automatic test_reset_mid();
        issue_request(1'b0, 1'b1, 32'h6B00_0000, 6'd8, 32'h0000_4000, 6'd24, 16'd4, 11'd5, 2'd3);
        @(negedge HCLK);
        spi_status = ST_BUSY; rready = 1; spi_data_rx_valid = 1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge HCLK);
            spi_data_rx = $urandom;
        end
        #1;
        checks++; if (dut.state !== ST_DATA) begin failures++; $display("[TB] FAIL rst_pre_state got=%0d exp=%0d", dut.state, ST_DATA); end
        HRESETn = 0;
        @(negedge HCLK);
        HRESETn = 1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if ({spi_rd, spi_qrd, spi_wr, spi_qwr, done} !== 5'b0) begin failures++; $display("[TB] FAIL rst_strobes got=%b exp=00000", {spi_rd, spi_qrd, spi_wr, spi_qwr, done}); end
        checks++; if ({spi_cmd, spi_addr, spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg} !== 128'd0) begin failures++; $display("[TB] FAIL rst_config got=%h exp=0", {spi_cmd, spi_addr, spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg}); end
        checks++; if ({rvalid, spi_data_rx_ready} !== 2'b00) begin failures++; $display("[TB] FAIL rst_data_path got=%b exp=00", {rvalid, spi_data_rx_ready}); end
        checks++; if (dut.words_left !== 11'd0) begin failures++; $display("[TB] FAIL rst_counter got=%0d exp=0", dut.words_left); end
        idle_inputs();
        @(negedge HCLK);
    endtask

    task automatic test_timeout();
        int n, done_n;
        bit seen;
        logic err_at_done;
        spi_status = ST_BUSY;
        issue_request(1'b0, 1'b0, 32'h0500_0000, 6'd8, 32'h0, 6'd0, 16'd0, 11'd0, 2'd0);
        n = 1; done_n = -1; seen = 0; err_at_done = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge HCLK); #1;
            n++;
            if (done) begin seen = 1; done_n = n; err_at_done = err; end
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        checks++; if (done_n != 104) begin failures++; $display("[TB] FAIL to_done_cycle got=%0d exp=104", done_n); end
        checks++; if (err_at_done !== 1'b1) begin failures++; $display("[TB] FAIL to_err got=%b exp=1", err_at_done); end
        spi_status = ST_IDL;
        @(negedge HCLK);
`else
        checks++; if (seen) begin failures++; $display("[TB] FAIL to_stuck_drain done_at=%0d exp=never", done_n); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL to_still_busy got=%b exp=0", req_ready); end
        spi_status = ST_IDL;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge HCLK); #1;
            if (done) begin seen = 1; err_at_done = err; end
        end
        checks++; if (!seen || err_at_done !== 1'b0) begin failures++; $display("[TB] FAIL to_release got=%b/%b exp=1/0", seen, err_at_done); end
        @(negedge HCLK);
`endif
    endtask

    initial begin
        test_reset();
        test_read(1'b1, 4, -1, 0);
        test_write();
        test_cmd_only();
        test_read(1'b0, 6, 2, 20);
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
